// File: rtl/boton_pkg.sv
// rtl/boton_pkg.sv - shared state encoding and default timing for the button event decoder
package boton_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } boton_state_e;

    // 100 us long-press and 20 us repeat at 50 MHz.
    localparam int LONG_DEF = 5000;
    localparam int REP_DEF  = 1000;

endpackage

// File: rtl/boton_evento.sv
// rtl/boton_evento.sv - turns a debounced button level into press/release/long/repeat pulses
module boton_evento
    import boton_pkg::*;
#(
    parameter int CW   = 16,
    parameter int LONG = LONG_DEF,
    parameter int REP  = REP_DEF
) (
    input  logic clkin,
    input  logic rstn,
    input  logic boton,
    output logic press,
    output logic release_p,
    output logic long_p,
    output logic rep,
    output logic held
);

    if (LONG < 1 || longint'(LONG) > (longint'(1) << CW)) begin : g_bad_long
        $error("boton_evento: LONG must lie in 1..2^CW");
    end
    if (REP < 1 || longint'(REP) > (longint'(1) << CW)) begin : g_bad_rep
        $error("boton_evento: REP must lie in 1..2^CW");
    end

    localparam logic [CW-1:0] LONG_T = CW'(LONG - 1);
    localparam logic [CW-1:0] REP_T  = CW'(REP - 1);

    boton_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;
    logic          held_q, held_d;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            rep_q     <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            rep_q     <= rep_d;
            held_q    <= held_d;
        end
    end

    // Release is checked first in every held state so it pre-empts a terminal count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        rep_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (boton) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            ARMED: begin
                if (!boton) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_T) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!boton) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REP_T) begin
                    cnt_d = '0;
                    rep_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    assign press     = press_q;
    assign release_p = release_q;
    assign long_p    = long_q;
    assign rep       = rep_q;
    assign held      = held_q;

endmodule
